axi_rd: RTL and testbench
=========================

Name: axi_rd

Overview:
AXI read-channel engine (AR/R) that serves refill and uncached read requests from the i-cache and d-cache. It is the read-side neighbour of the AXI write engine. It arbitrates between the two caches with d-cache priority and issues one outstanding AR transaction at a time. It assembles R beats into a line buffer and returns the whole line to the requester in a single-cycle pulse. It drives read_unfinish to hold off the write engine, and holds off d-cache reads until the write engine reports wr_idle.

Parameters:
BYTES_PER_LINE, 16, cache line size in bytes (power of 2, >= 8).
WORDS_PER_LINE, BYTES_PER_LINE/4, 32-bit words per line.
LINE_WIDTH, WORDS_PER_LINE*32, line buffer width.
PTR_WIDTH, $clog2(WORDS_PER_LINE), beat pointer width.

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
i_rd_req  in  1  i-cache read request
i_rd_rdy  out  1  i request accepted this cycle when high with i_rd_req
i_burst  in  1  1 = line refill, 0 = single beat
i_addr  in  32  request address
i_size  in  2  AXI size for single beat
i_ret_valid  out  1  one-cycle line-return pulse
i_ret_data  out  LINE_WIDTH  returned line
d_rd_req, d_rd_rdy, d_burst, d_addr, d_size, d_ret_valid, d_ret_data  same as i_* for d-cache
wr_idle  in  1  write engine empty and idle
read_unfinish  out  1  read transaction in flight
arid  out  4  0 = i, 1 = d
araddr  out  32
arlen  out  8
arsize  out  3
arburst  out  2
arlock  out  2  const 0
arcache  out  4  const 0
arprot  out  3  const 0
arvalid  out  1
arready  in  1
rid  in  4  unused
rdata  in  32
rresp  in  2  unused
rlast  in  1
rvalid  in  1
rready  out  1

Behaviour:
- Reset values: state IDLE. arvalid=0, rready=0, *_ret_valid=0, read_unfinish=0. Line buffer contents are don't-care.
- Reset mid-transaction returns to IDLE at once. The transaction is abandoned and no ret pulse is issued.
- States: IDLE, AR, R, RET.
- IDLE, arbitration (combinational):
  - d_rd_rdy = idle & wr_idle.
  - i_rd_rdy = idle & ~(d_rd_req & wr_idle).
  - A d request blocked by ~wr_idle does not block i.
- Accept (req & rdy):
  - Latch owner, addr, burst and size.
  - Clear the line buffer to 0 and set ptr=0.
  - Go to AR.
- AR:
  - arvalid=1 with stable fields until arready.
  - arvalid does not depend on arready.
  - Go to R on arready.
- AR fields, burst: araddr = addr with low log2(BYTES_PER_LINE) bits zeroed, arlen = WORDS_PER_LINE-1, arsize = 2, arburst = INCR.
- AR fields, single beat: araddr = addr, arlen = 0, arsize = {0,size}, arburst = FIXED.
- R:
  - rready=1.
  - Each rvalid beat writes rdata to word ptr (bits ptr*32+:32), then ptr+1. ptr wraps at WORDS_PER_LINE.
  - Single-beat reads fill word 0 only; the other words stay 0.
  - Go to RET on rvalid & rlast. rlast is authoritative; beat count is not checked.
- RET:
  - Owner's ret_valid=1 for exactly one cycle, with ret_data = line buffer.
  - ret_data holds its value until the next accept.
  - Next state is IDLE; a new request is acceptable the cycle after RET.
- read_unfinish = state in {AR, R}. Not asserted in IDLE, even with requests pending, to avoid deadlock with the write engine.
- Minimum latency, burst with arready and rvalid always high: accept at cycle 0, AR cycle 1, beats cycles 2..1+WORDS, ret_valid at cycle 2+WORDS.
- Simultaneous i and d requests with wr_idle=1: d wins; i stays pending and is served after RET.
- Only one outstanding transaction. rid and rresp are ignored.

Decomposition:
- Shared package: BURST_FIXED/BURST_INCR, AXI size constants, ARID_I/ARID_D, state encodings.
- Next-state select reuses the existing mux_1h, one-hot select per destination state.
- No further sub-module.

Test Plan:
- i burst, addr 0x1000_0004, arready/rvalid always 1, rdata 0xA0..0xA3:
  - AR: araddr=0x1000_0000, arlen=3, arsize=2, arburst=1, arid=0.
  - i_ret_valid one cycle at cycle 6, i_ret_data={A3,A2,A1,A0}.
- d single, addr 0x1FAF_F002, size 1, rdata 0x1234:
  - AR: arlen=0, arsize=1, arburst=0, araddr unchanged, arid=1.
  - d_ret_data = 0x...0000_1234.
- i and d requests in the same cycle, wr_idle=1:
  - d_rd_rdy=1, i_rd_rdy=0; d served first, i accepted the cycle after d RET.
- d request with wr_idle=0 for 5 cycles plus an i request:
  - i accepted immediately, d_rd_rdy=0 throughout.
  - d accepted once wr_idle=1 and the engine is in IDLE.
  - read_unfinish=0 while in IDLE.
- arready delayed 3 cycles and rvalid gapped (1,0,1,0,...):
  - arvalid and araddr held stable through the stall.
  - Line assembled in order; ret fires once, the cycle after the rlast beat.
- reset asserted during R after 2 beats:
  - Next cycle: IDLE, rready=0, no ret pulse.
  - A fresh request completes normally.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// Shared constants and types for the AXI read engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_rd_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_4B = 3'd2;

  localparam logic [3:0] ARID_I = 4'd0;
  localparam logic [3:0] ARID_D = 4'd1;

  localparam int NUM_STATES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RET  = 2'd3
  } state_e;

endpackage

// File: rtl/axi_rd_mux_1h.sv
// One-hot select mux: ORs together every input whose select bit is set.
// Latency: combinational.
// Backpressure: none.
// Ports: sel (one-hot select), din (N packed inputs of W bits), dout (selected value).
module axi_rd_mux_1h #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);

  always_comb begin
    dout = '0;
    for (int k = 0; k < N; k++) begin
      if (sel[k]) dout = dout | din[k];
    end
  end

endmodule

// File: rtl/axi_rd.sv
// AXI read engine: arbitrates i/d cache reads (d first), issues one AR, assembles R beats, returns the line.
// Latency: burst with no stalls returns the line 2+WORDS_PER_LINE cycles after accept.
// Backpressure: one transaction in flight; rdy low while busy, d also held off until wr_idle.
// Ports: i_*/d_* cache request and line-return interfaces, wr_idle/read_unfinish write-engine
//        interlock, ar*/r* AXI read address and data channels, clk/reset (sync active-high).
module axi_rd
  import axi_rd_pkg::*;
#(
  parameter int BYTES_PER_LINE = 16,
  parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
  parameter int LINE_WIDTH     = WORDS_PER_LINE * 32,
  parameter int PTR_WIDTH      = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rd_req,
  output logic                  i_rd_rdy,
  input  logic                  i_burst,
  input  logic [31:0]           i_addr,
  input  logic [1:0]            i_size,
  output logic                  i_ret_valid,
  output logic [LINE_WIDTH-1:0] i_ret_data,
  input  logic                  d_rd_req,
  output logic                  d_rd_rdy,
  input  logic                  d_burst,
  input  logic [31:0]           d_addr,
  input  logic [1:0]            d_size,
  output logic                  d_ret_valid,
  output logic [LINE_WIDTH-1:0] d_ret_data,
  input  logic                  wr_idle,
  output logic                  read_unfinish,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam logic [31:0] LINE_MASK = 32'(BYTES_PER_LINE - 1);

  state_e state_q, state_d;

  logic                                owner_q, owner_d;   // 1 = d-cache
  logic [31:0]                         addr_q, addr_d;
  logic                                burst_q, burst_d;
  logic [1:0]                          size_q, size_d;
  logic [WORDS_PER_LINE-1:0][31:0]     line_q, line_d;
  logic [PTR_WIDTH-1:0]                ptr_q, ptr_d;

  logic is_idle, is_ar, is_r, is_ret;
  logic i_acc, d_acc, accept, r_done;

  // rid/rresp are deliberately ignored: only one transaction is ever outstanding.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp};

  assign is_idle = (state_q == ST_IDLE);
  assign is_ar   = (state_q == ST_AR);
  assign is_r    = (state_q == ST_R);
  assign is_ret  = (state_q == ST_RET);

  assign d_acc  = d_rd_req & d_rd_rdy;
  assign i_acc  = i_rd_req & i_rd_rdy;
  assign accept = d_acc | i_acc;
  assign r_done = is_r & rvalid & rlast;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: one select line per destination state into the shared one-hot mux.
  logic [NUM_STATES-1:0]      st_sel;
  logic [NUM_STATES-1:0][1:0] st_enc;
  logic [1:0]                 st_nxt;

  always_comb begin
    for (int k = 0; k < NUM_STATES; k++) st_enc[k] = 2'(k);
    st_sel          = '0;
    st_sel[ST_IDLE] = (is_idle & ~accept) | is_ret;
    st_sel[ST_AR]   = (is_idle & accept) | (is_ar & ~arready);
    st_sel[ST_R]    = (is_ar & arready) | (is_r & ~(rvalid & rlast));
    st_sel[ST_RET]  = r_done;
  end

  axi_rd_mux_1h #(.N(NUM_STATES), .W(2)) u_state_mux (
    .sel  (st_sel),
    .din  (st_enc),
    .dout (st_nxt)
  );

  always_comb begin
    state_d = state_e'(st_nxt);
  end

  // Outputs. A blocked d request (wr_idle low) must not starve i.
  always_comb begin
    d_rd_rdy      = is_idle & wr_idle;
    i_rd_rdy      = is_idle & ~(d_rd_req & wr_idle);
    arvalid       = is_ar;
    rready        = is_r;
    i_ret_valid   = is_ret & ~owner_q;
    d_ret_valid   = is_ret & owner_q;
    // Not raised in IDLE with requests pending, otherwise the write engine could deadlock.
    read_unfinish = is_ar | is_r;
  end

  // Latched request and line assembly.
  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    size_d  = size_q;
    line_d  = line_q;
    ptr_d   = ptr_q;
    if (accept) begin
      owner_d = d_acc;
      addr_d  = d_acc ? d_addr  : i_addr;
      burst_d = d_acc ? d_burst : i_burst;
      size_d  = d_acc ? d_size  : i_size;
      line_d  = '0;
      ptr_d   = '0;
    end else if (is_r & rvalid) begin
      line_d[ptr_q] = rdata;
      ptr_d         = ptr_q + 1'b1;   // wraps naturally at WORDS_PER_LINE
    end
  end

  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    addr_q  <= addr_d;
    burst_q <= burst_d;
    size_q  <= size_d;
    line_q  <= line_d;
    ptr_q   <= ptr_d;
  end

  // AR fields come straight from latched state, so they are stable while arvalid waits.
  assign arid    = owner_q ? ARID_D : ARID_I;
  assign araddr  = burst_q ? (addr_q & ~LINE_MASK) : addr_q;
  assign arlen   = burst_q ? 8'(WORDS_PER_LINE - 1) : 8'd0;
  assign arsize  = burst_q ? SIZE_4B : {1'b0, size_q};
  assign arburst = burst_q ? BURST_INCR : BURST_FIXED;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign i_ret_data = line_q;
  assign d_ret_data = line_q;

endmodule

// File: tb/tb_axi_rd.sv
module tb_axi_rd;

  localparam int BYTES = 16;
  localparam int WORDS = BYTES / 4;
  localparam int LW    = WORDS * 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_rd_req = 1'b0, i_burst = 1'b0;
  logic [31:0]   i_addr = '0;
  logic [1:0]    i_size = '0;
  logic          d_rd_req = 1'b0, d_burst = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [1:0]    d_size = '0;
  logic          wr_idle = 1'b1;
  logic          arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
  logic [3:0]    rid = '0;
  logic [31:0]   rdata = '0;
  logic [1:0]    rresp = '0;
  logic          i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, read_unfinish;
  logic [LW-1:0] i_ret_data, d_ret_data;
  logic [3:0]    arid, arcache;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst, arlock;
  logic          arvalid, rready;

  int checks = 0;
  int errors = 0;

  axi_rd #(.BYTES_PER_LINE(BYTES)) dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_rdy(i_rd_rdy), .i_burst(i_burst), .i_addr(i_addr),
    .i_size(i_size), .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_rdy(d_rd_rdy), .d_burst(d_burst), .d_addr(d_addr),
    .d_size(d_size), .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
    .wr_idle(wr_idle), .read_unfinish(read_unfinish),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  // ---------------- AXI slave model ----------------
  // Drives at posedge+1, updates its bookkeeping at posedge+4. Tests drive at +2, sample at +3.
  int          ar_delay = 0;
  bit          gap_mode = 1'b0;
  int          ar_cnt = 0;
  bit          gap_ph = 1'b0;
  logic [31:0] pend_q[$];
  logic [31:0] src_q[$];
  logic [31:0] sent_q[$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      arready = arvalid && (ar_cnt >= ar_delay);
      rvalid  = (pend_q.size() > 0) && (!gap_mode || gap_ph);
      rdata   = (pend_q.size() > 0) ? pend_q[0] : 32'hDEAD_BEEF;
      rlast   = (pend_q.size() == 1);
      #3;
      if (reset) begin
        pend_q.delete();
        sent_q.delete();
        ar_cnt = 0;
        gap_ph = 1'b0;
      end else begin
        if (rvalid && rready) sent_q.push_back(pend_q.pop_front());
        if (arvalid && arready) begin
          for (int k = 0; k <= int'(arlen); k++) begin
            if (src_q.size() > 0) pend_q.push_back(src_q.pop_front());
            else                  pend_q.push_back($urandom);
          end
          ar_cnt = 0;
        end else if (arvalid) begin
          ar_cnt++;
        end
        gap_ph = ~gap_ph;
      end
    end
  end

  // ---------------- helpers (no comparisons) ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic smp;
    #1;
  endtask

  // Expected line from the beats the slave delivered: beat k lands in word k, rest zero.
  function automatic logic [LW-1:0] model_line(input bit burst);
    logic [LW-1:0] e;
    int n;
    e = '0;
    n = burst ? WORDS : 1;
    for (int k = 0; k < n; k++) begin
      if (sent_q.size() > 0) e[k*32 +: 32] = sent_q.pop_front();
    end
    return e;
  endfunction

  task automatic wait_ret(output int cyc, output bit got_i, output bit got_d,
                          output logic [LW-1:0] data);
    cyc = 0; got_i = 0; got_d = 0; data = '0;
    while (cyc < 200 && !got_i && !got_d) begin
      tick();
      smp();
      cyc++;
      got_i = i_ret_valid;
      got_d = d_ret_valid;
      data  = d_ret_valid ? d_ret_data : i_ret_data;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick();
    smp();
    checks++;
    if ({arvalid, rready, i_ret_valid, d_ret_valid, read_unfinish} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got arv/rr/iv/dv/ru=%b, want 00000",
               {arvalid, rready, i_ret_valid, d_ret_valid, read_unfinish});
    end
    checks++;
    if ({arlock, arcache, arprot} !== 9'b0) begin
      errors++;
      $display("FAIL reset_const: got %h, want 0", {arlock, arcache, arprot});
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_i_burst;
    int first = -1, n = 0;
    logic [LW-1:0] got = '0, want;
    ar_delay = 0; gap_mode = 0;
    sent_q.delete();
    src_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    tick();
    i_rd_req = 1; i_burst = 1; i_addr = 32'h1000_0004; i_size = 2'd2;
    smp();
    checks++;
    if (i_rd_rdy !== 1'b1) begin errors++; $display("FAIL ib_rdy: got %b want 1", i_rd_rdy); end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 1) i_rd_req = 0;
      smp();
      if (cyc == 1) begin
        checks++;
        if ({arvalid, read_unfinish, araddr, arlen, arsize, arburst, arid} !==
            {1'b1, 1'b1, 32'h1000_0000, 8'd3, 3'd2, 2'd1, 4'd0}) begin
          errors++;
          $display("FAIL ib_ar: got v=%b ru=%b a=%h len=%0d sz=%0d bu=%0d id=%0d, want 1 1 10000000 3 2 1 0",
                   arvalid, read_unfinish, araddr, arlen, arsize, arburst, arid);
        end
      end
      if (i_ret_valid) begin n++; if (first < 0) first = cyc; got = i_ret_data; end
    end
    want = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    checks++;
    if (first != 2 + WORDS || n != 1) begin
      errors++;
      $display("FAIL ib_latency: got first=%0d pulses=%0d, want %0d 1", first, n, 2 + WORDS);
    end
    checks++;
    if (got !== want) begin errors++; $display("FAIL ib_data: got %h want %h", got, want); end
    checks++;
    if (i_ret_data !== want) begin errors++; $display("FAIL ib_hold: got %h want %h", i_ret_data, want); end
  endtask

  task automatic test_d_single;
    int cyc; bit gi, gd; logic [LW-1:0] data;
    ar_delay = 0; gap_mode = 0;
    sent_q.delete();
    src_q = '{32'h0000_1234};
    tick();
    d_rd_req = 1; d_burst = 0; d_addr = 32'h1FAF_F002; d_size = 2'd1;
    smp();
    tick();
    d_rd_req = 0;
    smp();
    checks++;
    if ({arvalid, araddr, arlen, arsize, arburst, arid} !==
        {1'b1, 32'h1FAF_F002, 8'd0, 3'd1, 2'd0, 4'd1}) begin
      errors++;
      $display("FAIL ds_ar: got v=%b a=%h len=%0d sz=%0d bu=%0d id=%0d, want 1 1faff002 0 1 0 1",
               arvalid, araddr, arlen, arsize, arburst, arid);
    end
    wait_ret(cyc, gi, gd, data);
    checks++;
    if (!gd || gi || data !== LW'(32'h1234)) begin
      errors++;
      $display("FAIL ds_ret: got d=%b i=%b data=%h, want d=1 i=0 data=1234", gd, gi, data);
    end
  endtask

  task automatic test_simultaneous;
    int cyc; bit gi, gd; logic [LW-1:0] data, want;
    ar_delay = 0; gap_mode = 0;
    sent_q.delete(); src_q.delete();
    tick();
    wr_idle = 1;
    d_rd_req = 1; d_burst = 1; d_addr = $urandom;
    i_rd_req = 1; i_burst = 1; i_addr = $urandom;
    smp();
    checks++;
    if (d_rd_rdy !== 1'b1 || i_rd_rdy !== 1'b0) begin
      errors++; $display("FAIL sim_arb: got d_rdy=%b i_rdy=%b, want 1 0", d_rd_rdy, i_rd_rdy);
    end
    tick();
    d_rd_req = 0;
    smp();
    checks++;
    if (arid !== 4'd1) begin errors++; $display("FAIL sim_first_id: got %0d want 1", arid); end
    wait_ret(cyc, gi, gd, data);
    want = model_line(1'b1);
    checks++;
    if (!gd || data !== want || i_rd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL sim_d_ret: got d=%b i_rdy=%b data=%h, want d=1 i_rdy=0 data=%h", gd, i_rd_rdy, data, want);
    end
    tick();
    smp();
    checks++;
    if (i_rd_rdy !== 1'b1) begin errors++; $display("FAIL sim_i_after: got i_rdy=%b want 1", i_rd_rdy); end
    tick();
    i_rd_req = 0;
    smp();
    checks++;
    if (arvalid !== 1'b1 || arid !== 4'd0) begin
      errors++; $display("FAIL sim_second_ar: got v=%b id=%0d want 1 0", arvalid, arid);
    end
    wait_ret(cyc, gi, gd, data);
    want = model_line(1'b1);
    checks++;
    if (!gi || data !== want) begin
      errors++; $display("FAIL sim_i_ret: got i=%b data=%h want 1 %h", gi, data, want);
    end
  endtask

  task automatic test_wr_idle_block;
    int acc = -1, bad = 0, cyc; bit gi, gd;
    logic [LW-1:0] idata = '0, data, want;
    bit ig = 0;
    ar_delay = 0; gap_mode = 0;
    sent_q.delete(); src_q.delete();
    tick();
    wr_idle = 0;
    d_rd_req = 1; d_burst = 0; d_addr = $urandom; d_size = 2'd2;
    i_rd_req = 1; i_burst = 1; i_addr = $urandom;
    smp();
    checks++;
    if (d_rd_rdy !== 1'b0 || i_rd_rdy !== 1'b1 || read_unfinish !== 1'b0) begin
      errors++;
      $display("FAIL wi_start: got d_rdy=%b i_rdy=%b ru=%b, want 0 1 0", d_rd_rdy, i_rd_rdy, read_unfinish);
    end
    for (int c = 1; c <= 40 && acc < 0; c++) begin
      tick();
      if (c == 1) i_rd_req = 0;
      if (c == 5) wr_idle = 1;
      smp();
      if (c < 5 && d_rd_rdy) bad++;
      if (i_ret_valid) begin ig = 1; idata = i_ret_data; end
      if (d_rd_rdy) begin
        acc = c;
        checks++;
        if (read_unfinish !== 1'b0) begin
          errors++; $display("FAIL wi_ru_idle: got ru=%b want 0", read_unfinish);
        end
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wi_blocked: got %0d cycles d_rdy=1, want 0", bad); end
    checks++;
    if (acc != 3 + WORDS) begin errors++; $display("FAIL wi_accept_cyc: got %0d want %0d", acc, 3 + WORDS); end
    want = model_line(1'b1);
    checks++;
    if (!ig || idata !== want) begin
      errors++; $display("FAIL wi_i_ret: got seen=%b data=%h want 1 %h", ig, idata, want);
    end
    tick();
    d_rd_req = 0;
    wait_ret(cyc, gi, gd, data);
    want = model_line(1'b0);
    checks++;
    if (!gd || data !== want) begin
      errors++; $display("FAIL wi_d_ret: got d=%b data=%h want 1 %h", gd, data, want);
    end
  endtask

  task automatic test_stall;
    int arv_cyc = 0, bad_addr = 0, last_c = -1, ret_c = -1, n = 0;
    logic [31:0] exp_addr;
    logic [LW-1:0] got = '0, want;
    ar_delay = 3; gap_mode = 1;
    sent_q.delete(); src_q.delete();
    tick();
    i_rd_req = 1; i_burst = 1; i_addr = $urandom;
    exp_addr = (i_addr / BYTES) * BYTES;
    smp();
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 1) i_rd_req = 0;
      smp();
      if (arvalid) begin arv_cyc++; if (araddr !== exp_addr) bad_addr++; end
      if (i_ret_valid) begin n++; ret_c = c; got = i_ret_data; end
      if (rvalid && rready && rlast) last_c = c;
    end
    want = model_line(1'b1);
    checks++;
    if (arv_cyc != 4 || bad_addr != 0) begin
      errors++; $display("FAIL st_ar_hold: got arvalid cycles=%0d bad addr=%0d, want 4 0", arv_cyc, bad_addr);
    end
    checks++;
    if (n != 1 || last_c < 0 || ret_c != last_c + 1) begin
      errors++; $display("FAIL st_ret_timing: got pulses=%0d ret=%0d rlast=%0d, want 1 rlast+1", n, ret_c, last_c);
    end
    checks++;
    if (got !== want) begin errors++; $display("FAIL st_data: got %h want %h", got, want); end
    ar_delay = 0; gap_mode = 0;
  endtask

  task automatic test_reset_mid;
    int n = 0, cyc; bit gi, gd; logic [LW-1:0] data, want;
    ar_delay = 0; gap_mode = 0;
    sent_q.delete(); src_q.delete();
    tick();
    d_rd_req = 1; d_burst = 1; d_addr = $urandom;
    smp();
    tick(); d_rd_req = 0;     // AR
    tick();                   // beat 0
    tick();                   // beat 1
    tick();
    reset = 1;
    smp();
    tick();
    reset = 0;
    smp();
    checks++;
    if ({rready, arvalid, read_unfinish, d_ret_valid, i_ret_valid} !== 5'b0 || d_rd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rm_after: got rr/arv/ru/dv/iv=%b d_rdy=%b, want 00000 1",
               {rready, arvalid, read_unfinish, d_ret_valid, i_ret_valid}, d_rd_rdy);
    end
    for (int c = 0; c < 10; c++) begin
      tick(); smp();
      if (i_ret_valid || d_ret_valid) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL rm_no_ret: got %0d pulses want 0", n); end
    sent_q.delete();
    tick();
    i_rd_req = 1; i_burst = 1; i_addr = $urandom;
    smp();
    tick(); i_rd_req = 0;
    wait_ret(cyc, gi, gd, data);
    want = model_line(1'b1);
    checks++;
    if (!gi || data !== want) begin
      errors++; $display("FAIL rm_fresh: got i=%b data=%h want 1 %h", gi, data, want);
    end
  endtask

  task automatic test_random;
    bit isd, bu; logic [31:0] a; logic [1:0] sz;
    int cyc; bit gi, gd; logic [LW-1:0] data, want;
    logic [31:0] ea; logic [7:0] el; logic [2:0] es; logic [1:0] eb;
    sent_q.delete(); src_q.delete();
    for (int t = 0; t < 30; t++) begin
      ar_delay = $urandom_range(0, 3);
      gap_mode = $urandom_range(0, 1);
      isd = $urandom_range(0, 1);
      bu  = $urandom_range(0, 1);
      a   = $urandom;
      sz  = 2'($urandom_range(0, 2));
      ea  = bu ? (a / BYTES) * BYTES : a;
      el  = bu ? 8'(WORDS - 1) : 8'd0;
      es  = bu ? 3'd2 : {1'b0, sz};
      eb  = bu ? 2'd1 : 2'd0;
      tick();
      wr_idle = 1;
      if (isd) begin d_rd_req = 1; d_burst = bu; d_addr = a; d_size = sz; end
      else     begin i_rd_req = 1; i_burst = bu; i_addr = a; i_size = sz; end
      smp();
      tick();
      d_rd_req = 0; i_rd_req = 0;
      smp();
      checks++;
      if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b1, ea, el, es, eb, 3'b0, isd}) begin
        errors++;
        $display("FAIL rnd_ar[%0d]: got v=%b a=%h len=%0d sz=%0d bu=%0d id=%0d, want 1 %h %0d %0d %0d %0d",
                 t, arvalid, araddr, arlen, arsize, arburst, arid, ea, el, es, eb, isd);
      end
      wait_ret(cyc, gi, gd, data);
      want = model_line(bu);
      checks++;
      if (gd !== isd || gi !== !isd || data !== want) begin
        errors++;
        $display("FAIL rnd_ret[%0d]: got i=%b d=%b data=%h, want d=%b data=%h", t, gi, gd, data, isd, want);
      end
    end
    ar_delay = 0; gap_mode = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_i_burst();
    test_d_single();
    test_simultaneous();
    test_wr_idle_block();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
